// File: rtl/present_dom_pkg.sv
// Shared types and helpers for the two-share PRESENT-80 core.
// Optional build macro used by the core: PRESENT_DOM_UNMASK_DBG_EN.
package present_dom_pkg;

  localparam int ROUNDS   = 31;
  localparam int SBOX_LAT = 3;

  typedef enum logic [2:0] {IDLE, RND0, RND1, RND2, RND3, FIN} state_e;

  // Bit i moves to 16*i mod 63, bit 63 stays put.
  function automatic logic [63:0] player64(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    o[63] = d[63];
    for (int i = 0; i < 63; i++) o[(16 * i) % 63] = d[i];
    return o;
  endfunction

  function automatic logic [79:0] rotl61(input logic [79:0] k);
    return {k[18:0], k[79:19]};
  endfunction

endpackage

// File: rtl/present_dom_keysched.sv
// Masked PRESENT-80 key schedule: both key shares, the key S-box and round-counter injection.
module present_dom_keysched
  import present_dom_pkg::*;
(
  input  logic        clk_i,
  input  logic        load_i,
  input  logic        upd_i,
  input  logic [79:0] key0_i,
  input  logic [79:0] key1_i,
  input  logic        rnd_i,
  input  logic [4:0]  round_i,
  output logic [79:0] key0_o,
  output logic [79:0] key1_o
);

  logic [79:0] key0_q, key1_q, key0_d, key1_d, rot0, rot1;
  logic [3:0]  ks0, ks1;

  assign rot0 = rotl61(key0_q);
  assign rot1 = rotl61(key1_q);

  // Input is the post-rotation top nibble; it stays stable for the whole round.
  sbox u_ksbox (
    .clk (clk_i),   .r    (rnd_i),
    .x0_0(rot0[76]), .x1_0(rot0[77]), .x2_0(rot0[78]), .x3_0(rot0[79]),
    .x0_1(rot1[76]), .x1_1(rot1[77]), .x2_1(rot1[78]), .x3_1(rot1[79]),
    .Y0_0(ks0[0]),   .Y1_0(ks0[1]),   .Y2_0(ks0[2]),   .Y3_0(ks0[3]),
    .Y0_1(ks1[0]),   .Y1_1(ks1[1]),   .Y2_1(ks1[2]),   .Y3_1(ks1[3])
  );

  always_comb begin
    key0_d = key0_q;
    key1_d = key1_q;
    if (load_i) begin
      key0_d = key0_i;
      key1_d = key1_i;
    end else if (upd_i) begin
      key0_d = {ks0, rot0[75:0]};
      key0_d[19:15] = key0_d[19:15] ^ round_i;
      key1_d = {ks1, rot1[75:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    key0_q <= key0_d;
    key1_q <= key1_d;
  end

  assign key0_o = key0_q;
  assign key1_o = key1_q;

endmodule

// File: rtl/sbox.sv
// Two-share DOM PRESENT S-box, 3-cycle latency, no reset.
// Degree-2 terms in stage 1, degree-3 terms in stage 2, linear recombination in stage 3.
module sbox (
  input  logic clk,
  input  logic r,
  input  logic x0_0,
  input  logic x1_0,
  input  logic x2_0,
  input  logic x3_0,
  input  logic x0_1,
  input  logic x1_1,
  input  logic x2_1,
  input  logic x3_1,
  output logic Y0_0,
  output logic Y1_0,
  output logic Y2_0,
  output logic Y3_0,
  output logic Y0_1,
  output logic Y1_1,
  output logic Y2_1,
  output logic Y3_1
);

  // Product index: 0=x0x1 1=x0x2 2=x1x2 3=x1x3 4=x0x3 5=x2x3
  function automatic logic [5:0] opi(input logic [3:0] v);
    return {v[2], v[0], v[1], v[1], v[0], v[0]};
  endfunction
  function automatic logic [5:0] opj(input logic [3:0] v);
    return {v[3], v[3], v[3], v[2], v[2], v[1]};
  endfunction
  // Cubic index: 0=x0x1x2 1=x0x1x3 2=x0x2x3
  function automatic logic [2:0] cqa(input logic [5:0] q);
    return {q[1], q[0], q[0]};
  endfunction
  function automatic logic [2:0] cxb(input logic [3:0] v);
    return {v[3], v[3], v[2]};
  endfunction

  logic [1:0][3:0] x, xa_q, xb_q, y_d, y_q;
  logic [1:0][5:0] in1_q, cr1_q, q, q2_q;
  logic [1:0][2:0] in2_q, cr2_q, c;

  assign x[0] = {x3_0, x2_0, x1_0, x0_0};
  assign x[1] = {x3_1, x2_1, x1_1, x0_1};

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      xa_q[s]  <= x[s];
      in1_q[s] <= opi(x[s]) & opj(x[s]);
      cr1_q[s] <= (opi(x[s]) & opj(x[1-s])) ^ {6{r}};
      xb_q[s]  <= xa_q[s];
      q2_q[s]  <= q[s];
      in2_q[s] <= cqa(q[s]) & cxb(xa_q[s]);
      cr2_q[s] <= (cqa(q[s]) & cxb(xa_q[1-s])) ^ {3{r}};
      y_q[s]   <= y_d[s];
    end
  end

  always_comb begin
    q   = '0;
    c   = '0;
    y_d = '0;
    for (int s = 0; s < 2; s++) begin
      q[s] = in1_q[s] ^ cr1_q[s];
      c[s] = in2_q[s] ^ cr2_q[s];
      // The affine constant lives in share 0 only.
      y_d[s][0] = xb_q[s][0] ^ xb_q[s][2] ^ q2_q[s][2] ^ xb_q[s][3];
      y_d[s][1] = xb_q[s][1] ^ c[s][0] ^ xb_q[s][3] ^ q2_q[s][3] ^ c[s][1]
                ^ q2_q[s][5] ^ c[s][2];
      y_d[s][2] = (s == 0) ^ xb_q[s][2] ^ q2_q[s][0] ^ xb_q[s][3] ^ q2_q[s][4]
                ^ q2_q[s][3] ^ c[s][1] ^ c[s][2];
      y_d[s][3] = (s == 0) ^ xb_q[s][0] ^ xb_q[s][1] ^ q2_q[s][2] ^ c[s][0]
                ^ xb_q[s][3] ^ c[s][1] ^ c[s][2];
    end
  end

  assign {Y3_0, Y2_0, Y1_0, Y0_0} = y_q[0];
  assign {Y3_1, Y2_1, Y1_1, Y0_1} = y_q[1];

endmodule

// File: rtl/present_dom_core.sv
// Iterative two-share DOM PRESENT-80 encryption core, 4 cycles per round.
// Optional PRESENT_DOM_UNMASK_DBG_EN adds a recombined ct_dbg output for bring-up.
module present_dom_core
  import present_dom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pt_0,
  input  logic [63:0] pt_1,
  input  logic [79:0] key_0,
  input  logic [79:0] key_1,
  input  logic [16:0] rnd,
  output logic        busy,
  output logic        done,
  output logic [63:0] ct_0,
  output logic [63:0] ct_1
`ifdef PRESENT_DOM_UNMASK_DBG_EN
  ,
  output logic [63:0] ct_dbg
`endif
);

  state_e      st_q;
  logic [4:0]  round_q;
  logic        busy_q, done_q;
  logic [63:0] ct0_q, ct1_q;
  logic [63:0] st0_q, st1_q, sin0, sin1, sout0, sout1;
  logic [79:0] k0, k1;
  logic        accept;

  assign accept = (st_q == IDLE) && start;
  assign sin0   = st0_q ^ k0[79:16];
  assign sin1   = st1_q ^ k1[79:16];

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    sbox u_sbox (
      .clk (clk),           .r   (rnd[n]),
      .x0_0(sin0[4*n]),     .x1_0(sin0[4*n+1]),  .x2_0(sin0[4*n+2]),  .x3_0(sin0[4*n+3]),
      .x0_1(sin1[4*n]),     .x1_1(sin1[4*n+1]),  .x2_1(sin1[4*n+2]),  .x3_1(sin1[4*n+3]),
      .Y0_0(sout0[4*n]),    .Y1_0(sout0[4*n+1]), .Y2_0(sout0[4*n+2]), .Y3_0(sout0[4*n+3]),
      .Y0_1(sout1[4*n]),    .Y1_1(sout1[4*n+1]), .Y2_1(sout1[4*n+2]), .Y3_1(sout1[4*n+3])
    );
  end

  present_dom_keysched u_ks (
    .clk_i  (clk),
    .load_i (accept),
    .upd_i  (st_q == RND3),
    .key0_i (key_0),
    .key1_i (key_1),
    .rnd_i  (rnd[16]),
    .round_i(round_q),
    .key0_o (k0),
    .key1_o (k1)
  );

  // State shares carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      st0_q <= pt_0;
      st1_q <= pt_1;
    end else if (st_q == RND3) begin
      st0_q <= player64(sout0);
      st1_q <= player64(sout1);
    end
  end

`ifdef PRESENT_DOM_UNMASK_DBG_EN
  logic [63:0] ct_dbg_q;
  assign ct_dbg = ct_dbg_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ct0_q   <= '0;
      ct1_q   <= '0;
`ifdef PRESENT_DOM_UNMASK_DBG_EN
      ct_dbg_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (start) begin
          st_q    <= RND0;
          busy_q  <= 1'b1;
          round_q <= 5'd1;
        end
        RND0: st_q <= RND1;
        RND1: st_q <= RND2;
        RND2: st_q <= RND3;
        // Last round leaves the counter at ROUNDS so it never wraps.
        RND3: if (round_q == 5'(ROUNDS)) begin
          st_q <= FIN;
        end else begin
          st_q    <= RND0;
          round_q <= round_q + 5'd1;
        end
        FIN: begin
          ct0_q  <= sin0;
          ct1_q  <= sin1;
`ifdef PRESENT_DOM_UNMASK_DBG_EN
          ct_dbg_q <= sin0 ^ sin1;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ct_0 = ct0_q;
  assign ct_1 = ct1_q;

endmodule

// File: tb/tb_present_dom_core.sv
// Scoreboard bench for present_dom_core against an unmasked PRESENT-80 reference.
module tb_present_dom_core;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] pt_0, pt_1, ct_0, ct_1;
  logic [79:0] key_0, key_1;
  logic [16:0] rnd = '0;
  logic        busy, done;
`ifdef PRESENT_DOM_UNMASK_DBG_EN
  logic [63:0] ct_dbg;
`endif

  present_dom_core dut (
    .clk(clk), .rst(rst), .start(start),
    .pt_0(pt_0), .pt_1(pt_1), .key_0(key_0), .key_1(key_1), .rnd(rnd),
    .busy(busy), .done(done), .ct_0(ct_0), .ct_1(ct_1)
`ifdef PRESENT_DOM_UNMASK_DBG_EN
    , .ct_dbg(ct_dbg)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd = 17'($urandom);
  end

  typedef struct { logic [63:0] ct; int unsigned cyc; bit bias; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, ones = 0;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] present80(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s, t;
    logic [79:0] kk;
    s = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = SB[kk[79:76]];
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction
  function automatic logic [79:0] r80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d with no run pending", cyc);
      end else begin
        e = sb.pop_front();
        chk("ct", 80'(ct_0 ^ ct_1), 80'(e.ct));
        chk("latency", 80'(cyc), 80'(e.cyc));
`ifdef PRESENT_DOM_UNMASK_DBG_EN
        chk("ct_dbg", 80'(ct_dbg), 80'(e.ct));
`endif
        if (e.bias) ones += $countones(ct_0);
      end
    end
  end

  // Drives one start pulse with freshly masked shares; the accepting edge is the next one.
  task automatic issue(input logic [63:0] p, input logic [79:0] k, input logic [63:0] ex, input bit bias);
    logic [63:0] m;
    logic [79:0] km;
    m = r64();
    km = r80();
    pt_0 = p ^ m;
    pt_1 = m;
    key_0 = k ^ km;
    key_1 = km;
    start = 1'b1;
    sb.push_back('{ex, cyc + 126, bias});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d runs pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic [79:0] k;
    int t;
    rst = 1'b1;
    start = 1'b0;
    pt_0 = '0; pt_1 = '0; key_0 = '0; key_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 80'(busy), 80'(0));
    chk("reset_done", 80'(done), 80'(0));
    chk("reset_ct0", 80'(ct_0), 80'(0));
    chk("reset_ct1", 80'(ct_1), 80'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors under fresh masks.
    issue(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
    drain();
    for (int i = 0; i < 20; i++) begin
      issue(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
      drain();
    end

    // Starts while busy are ignored; a start in the done cycle is accepted.
    p = r64(); k = r80();
    issue(p, k, present80(p, k), 1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; pt_0 = r64();
    @(posedge clk); #1 start = 1'b0;
    repeat (113) @(posedge clk);
    #1 start = 1'b1; pt_0 = r64();
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (!done && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got done=0 expected done=1 within 10 cycles");
    end
    p = r64(); k = r80();
    issue(p, k, present80(p, k), 1'b0);
    drain();

    // Reset at relative cycle 60, with start raised alongside it.
    p = r64(); k = r80();
    issue(p, k, present80(p, k), 1'b0);
    repeat (59) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst_busy", 80'(busy), 80'(0));
    chk("midrst_done", 80'(done), 80'(0));
    chk("midrst_ct0", 80'(ct_0), 80'(0));
    chk("midrst_ct1", 80'(ct_1), 80'(0));
    sb.delete();
    @(posedge clk); #1;
    p = r64(); k = r80();
    issue(p, k, present80(p, k), 1'b0);
    drain();

    for (int i = 0; i < 20; i++) begin
      p = r64(); k = r80();
      issue(p, k, present80(p, k), 1'b0);
      drain();
    end

    // Fixed pt/key: recombined ct constant, share 0 alone near-balanced.
    p = 64'h0123456789ABCDEF; k = 80'h00112233445566778899;
    for (int i = 0; i < 100; i++) begin
      issue(p, k, present80(p, k), 1'b1);
      drain();
    end
    n_cmp++;
    if (ones < 2880 || ones > 3520) begin
      n_bad++;
      $display("FAIL share0_bias: got %0d ones of 6400 expected 2880..3520", ones);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
